mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have ports; clock and reset are single-domain, reset is synchronous and active-high:
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- ALUResultE_i  in  32  effective address / ALU result
- WriteDataE_i  in  32  store data (rs2)
- RdE_i  in  5  destination register
- RegWriteE_i  in  1  register write enable
- ResultSrcE_i  in  2  writeback select (passed through)
- PCPlus4E_i  in  32  return address (passed through)
- MemReadE_i  in  1  load
- MemWriteE_i  in  1  store
- MemSizeE_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- DMemReq_o  out  1  memory request valid
- DMemWe_o  out  1  1 = write
- DMemAddr_o  out  32  word address, bits[1:0] = 0
- DMemWData_o  out  32  lane-aligned store data
- DMemBe_o  out  4  byte enables
- DMemReady_i  in  1  memory accepts/completes the request this cycle
- DMemRData_i  in  32  read word, valid when DMemReady_i = 1
- ALUResultM_o, PCPlus4M_o  out  32  registered pass-through
- ReadDataM_o  out  32  formatted load data
- RdM_o  out  5, RegWriteM_o  out  1, ResultSrcM_o  out  2  registered pass-through
- StallM_o  out  1  execute stage must hold its outputs
- MisalignM_o  out  1  one-cycle misaligned-access flag

Function
REQ-003 SHALL implement FSM states IDLE and BUSY.
REQ-004 IDLE, no memory op: SHALL register all E inputs into M outputs on each edge (latency 1), with StallM_o = 0 and ReadDataM_o = 0.
REQ-005 IDLE, aligned memory op: SHALL assert StallM_o combinationally, latch address, size, store data and control fields, go to BUSY, and load a bubble into M (RegWriteM_o = 0).
REQ-006 BUSY: SHALL hold DMemReq_o = 1 with address, data, BE and WE stable, and keep StallM_o = 1, until DMemReady_i is sampled 1.
REQ-007 BUSY with DMemReady_i = 1: SHALL load the latched instruction fields and the formatted read data into M, deassert StallM_o, and return to IDLE on that edge.
REQ-008 Transaction latency SHALL be 2 + N cycles from issue to M-stage valid, where N is the number of BUSY cycles with DMemReady_i = 0.
REQ-009 If MemReadE_i and MemWriteE_i are both 1, the operation SHALL be treated as a store.
REQ-010 Alignment: W requires addr[1:0] = 00; H/HU require addr[0] = 0; B/BU are always aligned.
REQ-011 Misaligned op: SHALL issue no request, pass the instruction to M with RegWriteM_o = 0, assert MisalignM_o for exactly that cycle, and not stall.
REQ-012 Store lanes:
- SB: byte replicated to all lanes, BE = 0001 << addr[1:0].
- SH: halfword replicated to both halves, BE = 0011 << (2*addr[1]).
- SW: BE = 1111.
REQ-013 Load format: select the byte or halfword by addr[1:0]. B/H SHALL sign-extend; BU/HU SHALL zero-extend; W SHALL pass the word unchanged.
REQ-014 Stores SHALL set ReadDataM_o = 0. DMemAddr_o SHALL equal {addr[31:2], 2'b00}.
REQ-015 DMemReq_o SHALL be 0 in IDLE; DMemWe_o and DMemBe_o SHALL be 0 whenever DMemReq_o = 0.

Reset
REQ-016 With rst_i = 1 at a rising edge, the block SHALL enter IDLE and clear every registered output to 0.
REQ-017 On reset, DMemReq_o SHALL drop to 0 in the next cycle, including mid-BUSY, and the pending access SHALL be abandoned with no writeback.

Verification
REQ-018 The bench SHALL cover at least these directed scenarios:
- LW addr 0x100, DMemReady_i high on first BUSY cycle -> request with BE 1111; StallM_o high 2 cycles; ReadDataM_o = DMemRData_i; RegWriteM_o = 1.
- LB addr 0x103, DMemReady_i delayed 3 cycles, rdata 0x80FF_FF00 -> ReadDataM_o = 0xFFFF_FF80; request held stable throughout; StallM_o high 5 cycles.
- SH addr 0x202, data 0x1234_ABCD -> DMemWData_o = 0xABCD_ABCD, BE = 1100, DMemAddr_o = 0x200, RegWriteM_o = 0.
- LW addr 0x101 -> no DMemReq_o; MisalignM_o = 1 for one cycle; RegWriteM_o = 0; no stall.
- ALU op (RegWriteE_i = 1, Rd = 5, result 0x42) -> RdM_o = 5 and ALUResultM_o = 0x42 one cycle later; StallM_o = 0.
- rst_i asserted during BUSY -> DMemReq_o = 0 in the next cycle; all outputs 0; IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: issues one data-memory request per aligned load/store,
// stalls execute until memory completes, and formats load data into the M stage.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] ALUResultE_i,
  input  logic [DATA_WIDTH-1:0] WriteDataE_i,
  input  logic [4:0]            RdE_i,
  input  logic                  RegWriteE_i,
  input  logic [1:0]            ResultSrcE_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4E_i,
  input  logic                  MemReadE_i,
  input  logic                  MemWriteE_i,
  input  logic [2:0]            MemSizeE_i,
  output logic                  DMemReq_o,
  output logic                  DMemWe_o,
  output logic [DATA_WIDTH-1:0] DMemAddr_o,
  output logic [DATA_WIDTH-1:0] DMemWData_o,
  output logic [3:0]            DMemBe_o,
  input  logic                  DMemReady_i,
  input  logic [DATA_WIDTH-1:0] DMemRData_i,
  output logic [DATA_WIDTH-1:0] ALUResultM_o,
  output logic [DATA_WIDTH-1:0] PCPlus4M_o,
  output logic [DATA_WIDTH-1:0] ReadDataM_o,
  output logic [4:0]            RdM_o,
  output logic                  RegWriteM_o,
  output logic [1:0]            ResultSrcM_o,
  output logic                  StallM_o,
  output logic                  MisalignM_o,
  output logic                  o_dbg_busy
);

  // Handshake: DMemReq_o rises on the first BUSY cycle and stays high with address,
  // data, byte enables and write flag frozen; the cycle DMemReady_i is 1 completes it.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_alu, r_wdata, r_pc4;
  logic [3:0]            r_be;
  logic                  r_we, r_regwrite;
  logic [2:0]            r_size;
  logic [4:0]            r_rd;
  logic [1:0]            r_rsrc;
  logic [DATA_WIDTH-1:0] w_alu_nxt, w_wdata_nxt, w_pc4_nxt;
  logic [3:0]            w_be_nxt;
  logic                  w_we_nxt, w_regwrite_nxt;
  logic [2:0]            w_size_nxt;
  logic [4:0]            w_rd_nxt;
  logic [1:0]            w_rsrc_nxt;

  logic [DATA_WIDTH-1:0] r_alu_m, r_pc4_m, r_rdata_m;
  logic [4:0]            r_rd_m;
  logic                  r_regwrite_m, r_misalign_m;
  logic [1:0]            r_rsrc_m;
  logic [DATA_WIDTH-1:0] w_alu_m_nxt, w_pc4_m_nxt, w_rdata_m_nxt;
  logic [4:0]            w_rd_m_nxt;
  logic                  w_regwrite_m_nxt, w_misalign_m_nxt;
  logic [1:0]            w_rsrc_m_nxt;

  logic                  w_mem_op, w_aligned, w_stall;
  logic [DATA_WIDTH-1:0] w_st_data, w_load;
  logic [3:0]            w_st_be;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  assign w_mem_op = MemReadE_i | MemWriteE_i;

  // Lane placement for the incoming op; size[1:0] picks byte/half/word, size[2] only signedness.
  always_comb begin
    w_aligned = 1'b1;
    w_st_data = WriteDataE_i;
    w_st_be   = 4'b1111;
    case (MemSizeE_i[1:0])
      2'b00: begin
        w_st_data = {4{WriteDataE_i[7:0]}};
        w_st_be   = 4'b0001 << ALUResultE_i[1:0];
      end
      2'b01: begin
        w_aligned = ~ALUResultE_i[0];
        w_st_data = {2{WriteDataE_i[15:0]}};
        w_st_be   = 4'b0011 << {ALUResultE_i[1], 1'b0};
      end
      default: w_aligned = (ALUResultE_i[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    case (r_alu[1:0])
      2'd0:    w_byte = DMemRData_i[7:0];
      2'd1:    w_byte = DMemRData_i[15:8];
      2'd2:    w_byte = DMemRData_i[23:16];
      default: w_byte = DMemRData_i[31:24];
    endcase
    w_half = r_alu[1] ? DMemRData_i[31:16] : DMemRData_i[15:0];
    case (r_size[1:0])
      2'b00:   w_load = r_size[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_size[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = DMemRData_i;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_stall          = 1'b0;
    w_alu_nxt        = r_alu;
    w_wdata_nxt      = r_wdata;
    w_pc4_nxt        = r_pc4;
    w_be_nxt         = r_be;
    w_we_nxt         = r_we;
    w_regwrite_nxt   = r_regwrite;
    w_size_nxt       = r_size;
    w_rd_nxt         = r_rd;
    w_rsrc_nxt       = r_rsrc;
    w_alu_m_nxt      = r_alu_m;
    w_pc4_m_nxt      = r_pc4_m;
    w_rdata_m_nxt    = r_rdata_m;
    w_rd_m_nxt       = r_rd_m;
    w_regwrite_m_nxt = r_regwrite_m;
    w_rsrc_m_nxt     = r_rsrc_m;
    w_misalign_m_nxt = r_misalign_m;
    case (r_state)
      IDLE: begin
        if (w_mem_op && w_aligned) begin
          w_stall          = 1'b1;
          w_state_nxt      = BUSY;
          w_alu_nxt        = ALUResultE_i;
          w_wdata_nxt      = w_st_data;
          w_pc4_nxt        = PCPlus4E_i;
          w_be_nxt         = w_st_be;
          w_we_nxt         = MemWriteE_i;
          w_regwrite_nxt   = RegWriteE_i;
          w_size_nxt       = MemSizeE_i;
          w_rd_nxt         = RdE_i;
          w_rsrc_nxt       = ResultSrcE_i;
          w_alu_m_nxt      = '0;
          w_pc4_m_nxt      = '0;
          w_rdata_m_nxt    = '0;
          w_rd_m_nxt       = '0;
          w_regwrite_m_nxt = 1'b0;
          w_rsrc_m_nxt     = '0;
          w_misalign_m_nxt = 1'b0;
        end else begin
          // Plain ALU op, or a misaligned access that is dropped without writeback.
          w_alu_m_nxt      = ALUResultE_i;
          w_pc4_m_nxt      = PCPlus4E_i;
          w_rdata_m_nxt    = '0;
          w_rd_m_nxt       = RdE_i;
          w_regwrite_m_nxt = RegWriteE_i & ~w_mem_op;
          w_rsrc_m_nxt     = ResultSrcE_i;
          w_misalign_m_nxt = w_mem_op;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (DMemReady_i) begin
          w_state_nxt      = IDLE;
          w_alu_m_nxt      = r_alu;
          w_pc4_m_nxt      = r_pc4;
          w_rdata_m_nxt    = r_we ? '0 : w_load;
          w_rd_m_nxt       = r_rd;
          w_regwrite_m_nxt = r_regwrite;
          w_rsrc_m_nxt     = r_rsrc;
          w_misalign_m_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_alu        <= '0;
      r_wdata      <= '0;
      r_pc4        <= '0;
      r_be         <= '0;
      r_we         <= 1'b0;
      r_regwrite   <= 1'b0;
      r_size       <= '0;
      r_rd         <= '0;
      r_rsrc       <= '0;
      r_alu_m      <= '0;
      r_pc4_m      <= '0;
      r_rdata_m    <= '0;
      r_rd_m       <= '0;
      r_regwrite_m <= 1'b0;
      r_rsrc_m     <= '0;
      r_misalign_m <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_alu        <= w_alu_nxt;
      r_wdata      <= w_wdata_nxt;
      r_pc4        <= w_pc4_nxt;
      r_be         <= w_be_nxt;
      r_we         <= w_we_nxt;
      r_regwrite   <= w_regwrite_nxt;
      r_size       <= w_size_nxt;
      r_rd         <= w_rd_nxt;
      r_rsrc       <= w_rsrc_nxt;
      r_alu_m      <= w_alu_m_nxt;
      r_pc4_m      <= w_pc4_m_nxt;
      r_rdata_m    <= w_rdata_m_nxt;
      r_rd_m       <= w_rd_m_nxt;
      r_regwrite_m <= w_regwrite_m_nxt;
      r_rsrc_m     <= w_rsrc_m_nxt;
      r_misalign_m <= w_misalign_m_nxt;
    end
  end

  assign DMemReq_o    = (r_state == BUSY);
  assign o_dbg_busy   = (r_state == BUSY);
  assign DMemWe_o     = DMemReq_o & r_we;
  assign DMemBe_o     = DMemReq_o ? r_be : 4'b0000;
  assign DMemAddr_o   = {r_alu[DATA_WIDTH-1:2], 2'b00};
  assign DMemWData_o  = r_wdata;
  assign StallM_o     = w_stall;
  assign ALUResultM_o = r_alu_m;
  assign PCPlus4M_o   = r_pc4_m;
  assign ReadDataM_o  = r_rdata_m;
  assign RdM_o        = r_rd_m;
  assign RegWriteM_o  = r_regwrite_m;
  assign ResultSrcM_o = r_rsrc_m;
  assign MisalignM_o  = r_misalign_m;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: driver tasks push per-cycle expectations from a
// rule-level model; a negedge monitor pops and compares request/stall and M-stage outputs.
module tb_mem_access_unit;

  typedef struct packed {
    logic        stall, req, busy, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] alu, pc4, rdata;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  rsrc;
    logic        misalign;
  } mres_t;

  typedef struct packed {
    logic [31:0] alu, wd, pc4;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  rsrc;
    logic        mread, mwrite;
    logic [2:0]  size;
  } instr_t;

  localparam int CW = $bits(ctrl_t);
  localparam int MW = $bits(mres_t);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] alu_e = '0, wd_e = '0, pc4_e = '0, rdata_in = '0;
  logic [4:0]  rd_e = '0;
  logic        regwrite_e = 1'b0, mread_e = 1'b0, mwrite_e = 1'b0, ready = 1'b0;
  logic [1:0]  rsrc_e = '0;
  logic [2:0]  size_e = '0;
  logic        req, we, stall, misalign, regwrite_m, dbg_busy;
  logic [31:0] addr, wdata, alu_m, pc4_m, rdata_m;
  logic [3:0]  be;
  logic [4:0]  rd_m;
  logic [1:0]  rsrc_m;

  logic [CW-1:0] exp_ctrl_q[$];
  logic [MW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .ALUResultE_i(alu_e), .WriteDataE_i(wd_e), .RdE_i(rd_e), .RegWriteE_i(regwrite_e),
    .ResultSrcE_i(rsrc_e), .PCPlus4E_i(pc4_e), .MemReadE_i(mread_e), .MemWriteE_i(mwrite_e),
    .MemSizeE_i(size_e),
    .DMemReq_o(req), .DMemWe_o(we), .DMemAddr_o(addr), .DMemWData_o(wdata), .DMemBe_o(be),
    .DMemReady_i(ready), .DMemRData_i(rdata_in),
    .ALUResultM_o(alu_m), .PCPlus4M_o(pc4_m), .ReadDataM_o(rdata_m), .RdM_o(rd_m),
    .RegWriteM_o(regwrite_m), .ResultSrcM_o(rsrc_m), .StallM_o(stall), .MisalignM_o(misalign),
    .o_dbg_busy(dbg_busy)
  );

  // ---------------- reference model ----------------
  function automatic bit m_aligned(input logic [2:0] size, input logic [31:0] a);
    if (size == 3'd0 || size == 3'd4) return 1'b1;
    if (size == 3'd1 || size == 3'd5) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] size, input logic [31:0] a);
    int lane = int'(a % 4);
    if (size == 3'd0 || size == 3'd4) return 4'(1 << lane);
    if (size == 3'd1 || size == 3'd5) return 4'(3 << ((lane / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] size, input logic [31:0] d);
    if (size == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (size == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] size, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    int lane = int'(a % 4);
    case (size)
      3'd0, 3'd4: begin
        v = (w >> (8 * lane)) & 32'hFF;
        if (size == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * (lane / 2))) & 32'hFFFF;
        if (size == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input instr_t ins, input logic rdy, input logic [31:0] rd_word,
                       input logic rst_v);
    @(posedge clk); #1;
    alu_e = ins.alu; wd_e = ins.wd; pc4_e = ins.pc4; rd_e = ins.rd;
    regwrite_e = ins.regwrite; rsrc_e = ins.rsrc; mread_e = ins.mread;
    mwrite_e = ins.mwrite; size_e = ins.size;
    ready = rdy; rdata_in = rd_word; rst = rst_v;
    mon_en = 1'b1;
  endtask

  task automatic issue_op(input instr_t ins, input int n_wait, input logic [31:0] rd_word);
    bit mem = ins.mread | ins.mwrite;
    bit st  = ins.mwrite;
    ctrl_t c;
    mres_t m;
    drive(ins, 1'b0, $urandom, 1'b0);
    if (!mem || !m_aligned(ins.size, ins.alu)) begin
      c = '0;
      m = '{alu: ins.alu, pc4: ins.pc4, rdata: 32'd0, rd: ins.rd,
            regwrite: ins.regwrite & !mem, rsrc: ins.rsrc, misalign: mem};
      exp_ctrl_q.push_back(c);
      exp_q.push_back(m);
    end else begin
      c = '{stall: 1'b1, req: 1'b0, busy: 1'b0, we: 1'b0, be: 4'd0, addr: 32'd0, wdata: 32'd0};
      exp_ctrl_q.push_back(c);
      exp_q.push_back('0);
      for (int i = 0; i <= n_wait; i++) begin
        drive(ins, i == n_wait, (i == n_wait) ? rd_word : $urandom, 1'b0);
        c = '{stall: 1'b1, req: 1'b1, busy: 1'b1, we: st, be: m_be(ins.size, ins.alu),
              addr: ins.alu - (ins.alu % 4), wdata: m_wdata(ins.size, ins.wd)};
        exp_ctrl_q.push_back(c);
        if (i < n_wait) exp_q.push_back('0);
        else begin
          m = '{alu: ins.alu, pc4: ins.pc4, rdata: st ? 32'd0 : m_load(ins.size, ins.alu, rd_word),
                rd: ins.rd, regwrite: ins.regwrite, rsrc: ins.rsrc, misalign: 1'b0};
          exp_q.push_back(m);
        end
      end
    end
  endtask

  // Aligned access abandoned by reset after n_busy BUSY cycles without ready.
  task automatic reset_mid_busy(input instr_t ins, input int n_busy);
    ctrl_t c;
    drive(ins, 1'b0, $urandom, 1'b0);
    c = '{stall: 1'b1, req: 1'b0, busy: 1'b0, we: 1'b0, be: 4'd0, addr: 32'd0, wdata: 32'd0};
    exp_ctrl_q.push_back(c);
    exp_q.push_back('0);
    for (int i = 0; i <= n_busy; i++) begin
      drive(ins, 1'b0, $urandom, i == n_busy);
      c = '{stall: 1'b1, req: 1'b1, busy: 1'b1, we: ins.mwrite, be: m_be(ins.size, ins.alu),
            addr: ins.alu - (ins.alu % 4), wdata: m_wdata(ins.size, ins.wd)};
      exp_ctrl_q.push_back(c);
      exp_q.push_back('0);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  ctrl_t ec, gc;
  mres_t em, gm;
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      gc = '{stall: stall, req: req, busy: dbg_busy, we: we, be: be, addr: addr, wdata: wdata};
      gm = '{alu: alu_m, pc4: pc4_m, rdata: rdata_m, rd: rd_m, regwrite: regwrite_m,
             rsrc: rsrc_m, misalign: misalign};
      if (exp_ctrl_q.size() > 0) begin
        ec = exp_ctrl_q.pop_front();
        checks++;
        if (!(gc.stall === ec.stall && gc.req === ec.req && gc.busy === ec.busy &&
              gc.we === ec.we && gc.be === ec.be && (!ec.req || gc.addr === ec.addr) &&
              (!(ec.req && ec.we) || gc.wdata === ec.wdata))) begin
          errors++;
          $display("FAIL ctrl cyc=%0d got stall=%b req=%b busy=%b we=%b be=%b addr=%h wdata=%h exp stall=%b req=%b busy=%b we=%b be=%b addr=%h wdata=%h",
                   cyc, gc.stall, gc.req, gc.busy, gc.we, gc.be, gc.addr, gc.wdata,
                   ec.stall, ec.req, ec.busy, ec.we, ec.be, ec.addr, ec.wdata);
        end
      end
      if (exp_q.size() > 0) begin
        em = exp_q.pop_front();
        checks++;
        if (gm !== em) begin
          errors++;
          $display("FAIL mstage cyc=%0d got alu=%h pc4=%h rdata=%h rd=%0d rw=%b rsrc=%0d mis=%b exp alu=%h pc4=%h rdata=%h rd=%0d rw=%b rsrc=%0d mis=%b",
                   cyc, gm.alu, gm.pc4, gm.rdata, gm.rd, gm.regwrite, gm.rsrc, gm.misalign,
                   em.alu, em.pc4, em.rdata, em.rd, em.regwrite, em.rsrc, em.misalign);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  instr_t ins;
  int kind;
  logic [2:0] ld_sizes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    exp_q.push_back('0);

    ins = '{alu: 32'h42, wd: 32'h0, pc4: 32'h1004, rd: 5'd5, regwrite: 1'b1, rsrc: 2'd0,
            mread: 1'b0, mwrite: 1'b0, size: 3'd2};
    issue_op(ins, 0, 32'h0);
    ins = '{alu: 32'h100, wd: 32'h0, pc4: 32'h1008, rd: 5'd6, regwrite: 1'b1, rsrc: 2'd1,
            mread: 1'b1, mwrite: 1'b0, size: 3'd2};
    issue_op(ins, 0, 32'hDEAD_BEEF);
    ins = '{alu: 32'h103, wd: 32'h0, pc4: 32'h100C, rd: 5'd7, regwrite: 1'b1, rsrc: 2'd1,
            mread: 1'b1, mwrite: 1'b0, size: 3'd0};
    issue_op(ins, 3, 32'h80FF_FF00);
    ins = '{alu: 32'h202, wd: 32'h1234_ABCD, pc4: 32'h1010, rd: 5'd0, regwrite: 1'b0,
            rsrc: 2'd0, mread: 1'b0, mwrite: 1'b1, size: 3'd1};
    issue_op(ins, 1, 32'h5555_5555);
    ins = '{alu: 32'h101, wd: 32'h0, pc4: 32'h1014, rd: 5'd8, regwrite: 1'b1, rsrc: 2'd1,
            mread: 1'b1, mwrite: 1'b0, size: 3'd2};
    issue_op(ins, 0, 32'h0);
    ins = '{alu: 32'h300, wd: 32'h0, pc4: 32'h1018, rd: 5'd9, regwrite: 1'b1, rsrc: 2'd1,
            mread: 1'b1, mwrite: 1'b0, size: 3'd2};
    reset_mid_busy(ins, 2);
    ins = '{alu: 32'h77, wd: 32'h0, pc4: 32'h101C, rd: 5'd10, regwrite: 1'b1, rsrc: 2'd2,
            mread: 1'b0, mwrite: 1'b0, size: 3'd0};
    issue_op(ins, 0, 32'h0);

    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 11);
      ins.alu = $urandom; ins.wd = $urandom; ins.pc4 = $urandom;
      ins.rd = 5'($urandom); ins.regwrite = 1'($urandom); ins.rsrc = 2'($urandom);
      ins.mread = 1'b0; ins.mwrite = 1'b0;
      ins.size = ld_sizes[$urandom_range(0, 4)];
      if (kind >= 3 && $urandom_range(0, 1) == 1) ins.alu[1:0] = 2'b00;
      if (kind >= 3 && kind <= 6) ins.mread = 1'b1;
      else if (kind >= 7 && kind <= 9) begin
        ins.mwrite = 1'b1;
        ins.mread = (kind == 9);
        ins.size = 3'($urandom_range(0, 2));
      end
      if (kind == 10) begin
        ins.mread = 1'b1; ins.mwrite = 1'($urandom); ins.alu[1:0] = 2'b00;
        ins.size = 3'($urandom_range(0, 2));
        reset_mid_busy(ins, $urandom_range(0, 2));
      end else begin
        issue_op(ins, $urandom_range(0, 3), $urandom);
      end
    end

    ins = '0;
    issue_op(ins, 0, 32'h0);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_ctrl_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got ctrl_left=%0d m_left=%0d exp 0", exp_ctrl_q.size(), exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
